// File: rtl/pb_latch_pkg.sv
// Shared definitions for the push-button arbitration latch.
// Optional macro PB_LATCH_RELEASE_LOCK_EN: when defined, a clear is followed
// by a wait for both buttons to be released before the latch re-arms.
package pb_latch_pkg;

    // Arbitration states; WAIT_RELEASE is only reachable with the release lock built in.
    typedef enum logic [1:0] {
        ARMED        = 2'd0,
        LATCHED      = 2'd1,
        WAIT_RELEASE = 2'd2
    } state_e;

    localparam int SYNC_STAGES_DEFAULT = 2;

    // Result of a capture, packed as {push, tie, right}.
    // A simultaneous press is a tie and never credits the right player.
    function automatic logic [2:0] capture_result(input logic l, input logic r);
        logic [2:0] res;
        res[2] = l | r;
        res[1] = l & r;
        res[0] = r & ~l;
        return res;
    endfunction

endpackage

// File: rtl/pb_sync.sv
// Single-bit N-stage flip-flop synchronizer with asynchronous active-low reset.
module pb_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_reg;
    logic [STAGES-1:0] sync_next;

    // Shift the raw input in at the bottom of the chain.
    assign sync_next = STAGES'({sync_reg, d});

    // Synchronizer chain; cleared asynchronously on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= sync_next;
        end
    end

    assign q = sync_reg[STAGES-1];

endmodule

// File: rtl/pb_latch.sv
// Push-button arbitration latch: captures the first (or simultaneous) press of
// the left/right buttons and holds it until clr.
// Optional macro PB_LATCH_RELEASE_LOCK_EN: after clr, wait in WAIT_RELEASE
// until both buttons are released before re-arming.
module pb_latch
    import pb_latch_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic pbl,
    input  logic pbr,
    input  logic clr,
    output logic push,
    output logic tie,
    output logic right
);

`ifdef PB_LATCH_RELEASE_LOCK_EN
    localparam state_e AFTER_CLR = WAIT_RELEASE;
`else
    localparam state_e AFTER_CLR = ARMED;
`endif

    logic [2:0] raw_in;
    logic [2:0] synced;
    logic       pbl_s;
    logic       pbr_s;
    logic       clr_s;

    assign raw_in = {clr, pbr, pbl};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_sync
            pb_sync #(
                .STAGES(SYNC_STAGES)
            ) u_sync (
                .clk(clk),
                .rst(rst),
                .d  (raw_in[gi]),
                .q  (synced[gi])
            );
        end
    endgenerate

    assign pbl_s = synced[0];
    assign pbr_s = synced[1];
    assign clr_s = synced[2];

    state_e state_reg;
    logic   push_reg;
    logic   tie_reg;
    logic   right_reg;

    // Arbitration FSM with registered outputs; clr wins over a press in ARMED.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ARMED;
            push_reg  <= 1'b0;
            tie_reg   <= 1'b0;
            right_reg <= 1'b0;
        end else begin
            case (state_reg)
                ARMED: begin
                    if (!clr_s && (pbl_s || pbr_s)) begin
                        state_reg                       <= LATCHED;
                        {push_reg, tie_reg, right_reg}  <= capture_result(pbl_s, pbr_s);
                    end
                end
                LATCHED: begin
                    if (clr_s) begin
                        state_reg <= AFTER_CLR;
                        push_reg  <= 1'b0;
                        tie_reg   <= 1'b0;
                        right_reg <= 1'b0;
                    end
                end
                WAIT_RELEASE: begin
                    push_reg  <= 1'b0;
                    tie_reg   <= 1'b0;
                    right_reg <= 1'b0;
                    if (!pbl_s && !pbr_s) begin
                        state_reg <= ARMED;
                    end
                end
                default: begin
                    state_reg <= ARMED;
                    push_reg  <= 1'b0;
                    tie_reg   <= 1'b0;
                    right_reg <= 1'b0;
                end
            endcase
        end
    end

    assign push  = push_reg;
    assign tie   = tie_reg;
    assign right = right_reg;

endmodule

// File: tb/tb_pb_latch.sv
// Self-checking bench for pb_latch: directed scenarios plus randomized button
// activity, all compared against a behavioural model of the game rules.
module tb_pb_latch;

    localparam int N = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic pbl = 1'b0;
    logic pbr = 1'b0;
    logic clr = 1'b0;
    logic push;
    logic tie;
    logic right;

    int vectors     = 0;
    int miscompares = 0;

    pb_latch #(
        .SYNC_STAGES(N)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .pbl  (pbl),
        .pbr  (pbr),
        .clr  (clr),
        .push (push),
        .tie  (tie),
        .right(right)
    );

    always #5 clk = ~clk;

    // Model: inputs reach the arbiter N edges after being sampled.
    bit q_l[$];
    bit q_r[$];
    bit q_c[$];
    bit m_push, m_tie, m_right, m_wait;

    function automatic void model_reset();
        q_l = {};
        q_r = {};
        q_c = {};
        for (int i = 0; i < N; i++) begin
            q_l.push_back(1'b0);
            q_r.push_back(1'b0);
            q_c.push_back(1'b0);
        end
        m_push  = 1'b0;
        m_tie   = 1'b0;
        m_right = 1'b0;
        m_wait  = 1'b0;
    endfunction

    function automatic void model_edge(input bit l_in, input bit r_in, input bit c_in);
        bit l, r, c;
        l = q_l.pop_front();
        r = q_r.pop_front();
        c = q_c.pop_front();
        q_l.push_back(l_in);
        q_r.push_back(r_in);
        q_c.push_back(c_in);
        if (m_push) begin
            if (c) begin
                m_push  = 1'b0;
                m_tie   = 1'b0;
                m_right = 1'b0;
`ifdef PB_LATCH_RELEASE_LOCK_EN
                m_wait  = 1'b1;
`endif
            end
        end else if (m_wait) begin
            if (!l && !r) m_wait = 1'b0;
        end else if (!c && (l || r)) begin
            m_push  = 1'b1;
            m_tie   = l && r;
            m_right = r && !l;
        end
    endfunction

    function automatic logic [2:0] expected();
        return {m_push, m_tie, m_right};
    endfunction

    // Advance one clock: model follows the rising edge, bench returns on the falling edge.
    task automatic tick();
        @(posedge clk);
        if (rst) model_edge(pbl, pbr, clr);
        else     model_reset();
        @(negedge clk);
    endtask

    task automatic test_reset();
        #12;
        vectors++;
        if ({push, tie, right} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_during: got %b want 000", {push, tie, right});
        end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if ({push, tie, right} !== 3'b000) begin
                miscompares++;
                $display("FAIL reset_after cyc%0d: got %b want 000", i, {push, tie, right});
            end
        end
        $display("test_reset done");
    endtask

    task automatic test_right_press();
        pbr = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            vectors++;
            if ({push, tie, right} !== expected()) begin
                miscompares++;
                $display("FAIL right_press cyc%0d: got %b want %b", i, {push, tie, right}, expected());
            end
            if (i == N - 1) begin
                vectors++;
                if ({push, tie, right} !== 3'b000) begin
                    miscompares++;
                    $display("FAIL right_early: got %b want 000", {push, tie, right});
                end
            end
            if (i == N) begin
                vectors++;
                if ({push, tie, right} !== 3'b101) begin
                    miscompares++;
                    $display("FAIL right_latency: got %b want 101", {push, tie, right});
                end
            end
        end
        pbr = 1'b0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int i = 0; i < N + 1; i++) tick();
        vectors++;
        if ({push, tie, right} !== 3'b000) begin
            miscompares++;
            $display("FAIL right_clr: got %b want 000", {push, tie, right});
        end
        $display("test_right_press done");
    endtask

    task automatic test_left_press();
        pbl = 1'b1;
        for (int i = 0; i < N + 1; i++) tick();
        vectors++;
        if ({push, tie, right} !== 3'b100) begin
            miscompares++;
            $display("FAIL left_press: got %b want 100", {push, tie, right});
        end
        pbr = 1'b1;
        for (int i = 0; i < N + 2; i++) begin
            tick();
            vectors++;
            if ({push, tie, right} !== 3'b100 || expected() !== 3'b100) begin
                miscompares++;
                $display("FAIL left_hold cyc%0d: got %b want 100", i, {push, tie, right});
            end
        end
        pbl = 1'b0;
        pbr = 1'b0;
        for (int i = 0; i < N + 1; i++) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int i = 0; i < N + 1; i++) tick();
        vectors++;
        if ({push, tie, right} !== 3'b000) begin
            miscompares++;
            $display("FAIL left_clr: got %b want 000", {push, tie, right});
        end
        $display("test_left_press done");
    endtask

    task automatic test_tie();
        pbl = 1'b1;
        pbr = 1'b1;
        for (int i = 0; i < N + 1; i++) tick();
        vectors++;
        if ({push, tie, right} !== 3'b110) begin
            miscompares++;
            $display("FAIL tie_press: got %b want 110", {push, tie, right});
        end
        pbl = 1'b0;
        pbr = 1'b0;
        for (int i = 0; i < N + 1; i++) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int i = 0; i < N + 1; i++) tick();
        vectors++;
        if ({push, tie, right} !== 3'b000) begin
            miscompares++;
            $display("FAIL tie_clr: got %b want 000", {push, tie, right});
        end
        $display("test_tie done");
    endtask

    task automatic test_no_press();
        for (int i = 0; i < 10 + N + 2; i++) begin
            clr = (i == 10);
            tick();
            vectors++;
            if ({push, tie, right} !== 3'b000) begin
                miscompares++;
                $display("FAIL no_press cyc%0d: got %b want 000", i, {push, tie, right});
            end
        end
        clr = 1'b0;
        $display("test_no_press done");
    endtask

    task automatic test_clr_priority();
        clr = 1'b1;
        pbr = 1'b1;
        tick();
        clr = 1'b0;
        pbr = 1'b0;
        for (int i = 0; i < N + 3; i++) begin
            tick();
            vectors++;
            if ({push, tie, right} !== 3'b000) begin
                miscompares++;
                $display("FAIL clr_priority cyc%0d: got %b want 000", i, {push, tie, right});
            end
        end
        $display("test_clr_priority done");
    endtask

    task automatic test_release_lock();
        logic [2:0] want_held;
`ifdef PB_LATCH_RELEASE_LOCK_EN
        want_held = 3'b000;
`else
        want_held = 3'b101;
`endif
        pbr = 1'b1;
        for (int i = 0; i < N + 1; i++) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int i = 0; i < N + 2; i++) tick();
        vectors++;
        if ({push, tie, right} !== want_held || expected() !== want_held) begin
            miscompares++;
            $display("FAIL held_through_clr: got %b want %b", {push, tie, right}, want_held);
        end
        pbr = 1'b0;
        for (int i = 0; i < N + 2; i++) tick();
        pbr = 1'b1;
        for (int i = 0; i < N + 1; i++) tick();
        vectors++;
        if ({push, tie, right} !== 3'b101) begin
            miscompares++;
            $display("FAIL repress: got %b want 101", {push, tie, right});
        end
        pbr = 1'b0;
        for (int i = 0; i < N + 1; i++) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int i = 0; i < N + 2; i++) tick();
        vectors++;
        if ({push, tie, right} !== 3'b000) begin
            miscompares++;
            $display("FAIL lock_cleanup: got %b want 000", {push, tie, right});
        end
        $display("test_release_lock done");
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                #2 rst = 1'b0;
                #1;
                model_reset();
                vectors++;
                if ({push, tie, right} !== 3'b000) begin
                    miscompares++;
                    $display("FAIL async_reset cyc%0d: got %b want 000", i, {push, tie, right});
                end
                tick();
                rst = 1'b1;
            end
            if ($urandom_range(0, 7) == 0) pbl = ~pbl;
            if ($urandom_range(0, 7) == 0) pbr = ~pbr;
            clr = ($urandom_range(0, 15) == 0);
            tick();
            vectors++;
            if ({push, tie, right} !== expected()) begin
                miscompares++;
                $display("FAIL random cyc%0d: l=%b r=%b c=%b got %b want %b",
                         i, pbl, pbr, clr, {push, tie, right}, expected());
            end
        end
        $display("test_random done");
    endtask

    initial begin
        model_reset();
        test_reset();
        test_right_press();
        test_left_press();
        test_tie();
        test_no_press();
        test_clr_priority();
        test_release_lock();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
